// File: rtl/subsq_pkg.sv
// Shared types and constants for the Subtract-a-Square turn controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DEF_STATE_W        default pile / move width
//   turn_state_t       turn FSM state encoding
//   is_perfect_square  nonzero-square test at the default width
package subsq_pkg;

  localparam int DEF_STATE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MOVE,
    CHECK,
    APPLY,
    DONE
  } turn_state_t;

  // The largest square that fits in DEF_STATE_W bits has a root below
  // 2^(DEF_STATE_W/2), so these candidate roots cover every square in range.
  function automatic logic is_perfect_square(input logic [DEF_STATE_W-1:0] v);
    logic hit;
    hit = 1'b0;
    for (int k = 1; k < (1 << (DEF_STATE_W / 2)); k++) begin
      if (v == DEF_STATE_W'(k * k)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/subsq_square_check.sv
// Flags whether a move value is a nonzero perfect square.
// Latency: combinational (0 cycles).
// Backpressure: none; this is a pure function of its input.
//
// Ports:
//   move_val   in  W  candidate move
//   is_square  out 1  move_val equals k*k for some k in 1..2^(W/2)-1
module subsq_square_check
  import subsq_pkg::*;
#(
  parameter int W = DEF_STATE_W
) (
  input  logic [W-1:0] move_val,
  output logic         is_square
);

  // Parallel compare against every candidate square. k starts at 1, so a
  // zero move can never match.
  always_comb begin
    is_square = 1'b0;
    for (int k = 1; k < (1 << (W / 2)); k++) begin
      if (move_val == W'(k * k)) is_square = 1'b1;
    end
  end

endmodule

// File: rtl/subsq_turn_ctrl.sv
// Subtract-a-Square turn controller: holds the pile, checks each move and
// alternates players.
// Latency: move accepted in cycle N -> pile/player/pulses visible in N+2.
// Backpressure: move_ready is high only in WAIT_MOVE, low for N+1 and N+2.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   new_game       1-cycle pulse, loads start_pile (accepted in any state)
//   start_pile     initial pile size
//   move_valid     move offered; accepted while move_ready is high
//   move_ready     controller is waiting for a move
//   move_val       tokens to remove
//   game_state     current pile
//   player         player to move (0 = P1, 1 = P2); the winner once done
//   update_score   1-cycle pulse when the pile reaches zero
//   illegal_move   1-cycle pulse when a move is rejected (or a turn forfeited)
//   game_over      high while the game is finished
//
// Optional feature: define SUBSQ_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYCLES cycles in WAIT_MOVE without an accepted move.
module subsq_turn_ctrl
  import subsq_pkg::*;
#(
  parameter int STATE_W = DEF_STATE_W
`ifdef SUBSQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic [STATE_W-1:0] start_pile,
  input  logic               move_valid,
  output logic               move_ready,
  input  logic [STATE_W-1:0] move_val,
  output logic [STATE_W-1:0] game_state,
  output logic               player,
  output logic               update_score,
  output logic               illegal_move,
  output logic               game_over
);

  turn_state_t        state_q;
  turn_state_t        state_d;
  logic [STATE_W-1:0] move_q;
  logic               is_square;
  logic               legal;
  logic               wins;
  logic               forfeit;

  subsq_square_check #(
    .W(STATE_W)
  ) u_square_check (
    .move_val (move_q),
    .is_square(is_square)
  );

  // move_q <= game_state also guarantees the subtraction cannot wrap.
  assign legal = is_square && (move_q <= game_state);
  assign wins  = legal && (move_q == game_state);

`ifdef SUBSQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt;

  assign forfeit = (state_q == WAIT_MOVE) && !move_valid && !new_game &&
                   (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts cycles in the current WAIT_MOVE visit. It reads 0 in the first
  // cycle of every visit, including a restart by new_game or a forfeit.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state_q != WAIT_MOVE || state_d != WAIT_MOVE || new_game || forfeit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign forfeit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The winning move goes straight to DONE so that update_score and
  // game_over appear together. Every other checked move, legal or not,
  // spends one APPLY cycle so move_ready stays low through N+2.
  always_comb begin
    state_d    = state_q;
    move_ready = 1'b0;
    game_over  = 1'b0;

    if (new_game) begin
      state_d = (start_pile == '0) ? DONE : WAIT_MOVE;
    end else begin
      case (state_q)
        IDLE:      state_d = IDLE;
        WAIT_MOVE: if (move_valid) state_d = CHECK;
        CHECK:     state_d = wins ? DONE : APPLY;
        APPLY:     state_d = WAIT_MOVE;
        DONE:      state_d = DONE;
        default:   state_d = IDLE;
      endcase
    end

    case (state_q)
      WAIT_MOVE: move_ready = 1'b1;
      DONE:      game_over  = 1'b1;
      default:   ;
    endcase
  end

  // Pile, player and pulses are all registered at the end of CHECK, so they
  // are visible together in the cycle after CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      game_state   <= '0;
      player       <= 1'b0;
      move_q       <= '0;
      update_score <= 1'b0;
      illegal_move <= 1'b0;
    end else begin
      update_score <= 1'b0;
      illegal_move <= 1'b0;
      if (new_game) begin
        // Leaving CHECK this way drops any in-flight move.
        game_state <= start_pile;
        player     <= 1'b0;
      end else begin
        case (state_q)
          WAIT_MOVE: begin
            if (move_valid) begin
              move_q <= move_val;
            end else if (forfeit) begin
              player       <= ~player;
              illegal_move <= 1'b1;
            end
          end
          CHECK: begin
            if (!legal) begin
              illegal_move <= 1'b1;
            end else begin
              game_state <= game_state - move_q;
              if (wins) update_score <= 1'b1;
              else      player       <= ~player;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
